tick_divider: RTL and testbench

- Consumes the free-running 100 MHz master clock and derives slower timing from it.
- Produces a single-cycle clock-enable `tick` every N enabled cycles, plus a 50%-duty divided square wave `clk_div`.
- Keeps a wrapping tick counter.
- Downstream logic (LED blinkers, debouncers, counters) stays on `clk` and qualifies with `tick`. No logic is clocked by `clk_div`.
- N is programmable at run time.

---
 rtl/tick_divider.sv | 97 +++++++++
 tb/tb_tick_divider.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/tick_divider.sv
// Programmable clock-enable generator: one-cycle tick every N enabled cycles,
// a 50% divided square wave that toggles on each tick, and a wrapping tick counter.
module tick_divider #(
  parameter int DIV_WIDTH   = 27,
  parameter int DEFAULT_DIV = 100000000,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 restart,
  input  logic                 div_load,
  input  logic [DIV_WIDTH-1:0] div_value,
  output logic                 tick,
  output logic                 clk_div,
  output logic [CNT_WIDTH-1:0] tick_count,
  output logic [DIV_WIDTH-1:0] div_active,
  output logic                 div_err
);

  if (DEFAULT_DIV < 1 || longint'(DEFAULT_DIV) >= (longint'(1) << DIV_WIDTH)) begin : g_bad_default
    $error("tick_divider: DEFAULT_DIV must be >= 1 and < 2**DIV_WIDTH");
  end

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic                 tick_q, tick_d;
  logic                 clk_div_q, clk_div_d;
  logic [CNT_WIDTH-1:0] tick_count_q, tick_count_d;
  logic [DIV_WIDTH-1:0] div_active_q, div_active_d;
  logic                 div_err_q, div_err_d;

  logic load_ok;
  logic load_bad;
  logic terminal;

  assign load_ok  = div_load && (div_value != '0);
  assign load_bad = div_load && (div_value == '0);
  assign terminal = en && (cnt_q == div_active_q - DIV_WIDTH'(1));

  always_comb begin
    cnt_d        = cnt_q;
    tick_d       = 1'b0;
    clk_div_d    = clk_div_q;
    tick_count_d = tick_count_q;
    div_active_d = div_active_q;
    div_err_d    = 1'b0;

    if (restart) begin
      cnt_d        = '0;
      clk_div_d    = 1'b0;
      tick_count_d = '0;
      // A load arriving with restart is still honoured or rejected.
      if (load_ok) begin
        div_active_d = div_value;
      end
      div_err_d = load_bad;
    end else if (load_ok) begin
      div_active_d = div_value;
      cnt_d        = '0;
    end else begin
      div_err_d = load_bad;
      if (terminal) begin
        cnt_d        = '0;
        tick_d       = 1'b1;
        clk_div_d    = ~clk_div_q;
        tick_count_d = tick_count_q + CNT_WIDTH'(1);
      end else if (en) begin
        cnt_d = cnt_q + DIV_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      tick_q       <= 1'b0;
      clk_div_q    <= 1'b0;
      tick_count_q <= '0;
      div_active_q <= DIV_WIDTH'(DEFAULT_DIV);
      div_err_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      tick_q       <= tick_d;
      clk_div_q    <= clk_div_d;
      tick_count_q <= tick_count_d;
      div_active_q <= div_active_d;
      div_err_q    <= div_err_d;
    end
  end

  assign tick       = tick_q;
  assign clk_div    = clk_div_q;
  assign tick_count = tick_count_q;
  assign div_active = div_active_q;
  assign div_err    = div_err_q;

endmodule

// File: tb/tb_tick_divider.sv
// Self-checking bench for tick_divider: directed vector table, hand-written
// corner sequences, and randomized stimulus against an edge-counting model.
module tb_tick_divider;

  localparam int DW = 8;
  localparam int CW = 4;
  localparam int DEF = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en, restart, div_load;
  logic [DW-1:0] div_value;
  logic          tick, clk_div, div_err;
  logic [CW-1:0] tick_count;
  logic [DW-1:0] div_active;

  int checks = 0;
  int failures = 0;

  // Model: enabled edges since last phase clear, ticks since last restart/reset.
  int m_edges, m_ticks, m_div;
  bit m_tick, m_err;

  typedef struct {
    bit       en;
    bit       rs;
    bit       ld;
    bit [7:0] val;
    bit       e_tick;
    bit       e_cd;
    int       e_tc;
    int       e_da;
    bit       e_err;
  } vec_t;

  vec_t vecs[19];

  tick_divider #(.DIV_WIDTH(DW), .DEFAULT_DIV(DEF), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .restart(restart),
    .div_load(div_load), .div_value(div_value),
    .tick(tick), .clk_div(clk_div), .tick_count(tick_count),
    .div_active(div_active), .div_err(div_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_edges = 0; m_ticks = 0; m_div = DEF; m_tick = 0; m_err = 0;
  endtask

  task automatic model_edge(input bit e, input bit r, input bit l, input int v);
    m_tick = 0;
    m_err  = 0;
    if (r) begin
      m_edges = 0;
      m_ticks = 0;
      if (l && v != 0) m_div = v;
      else if (l) m_err = 1;
    end else if (l && v != 0) begin
      m_div   = v;
      m_edges = 0;
    end else begin
      if (l) m_err = 1;
      if (e) begin
        m_edges++;
        if (m_edges % m_div == 0) begin
          m_tick = 1;
          m_ticks++;
        end
      end
    end
  endtask

  task automatic compare_model(input string tag);
    chk({tag, ".tick"},       32'(tick),       32'(m_tick));
    chk({tag, ".clk_div"},    32'(clk_div),    32'(m_ticks % 2));
    chk({tag, ".tick_count"}, 32'(tick_count), 32'(m_ticks % (1 << CW)));
    chk({tag, ".div_active"}, 32'(div_active), 32'(m_div));
    chk({tag, ".div_err"},    32'(div_err),    32'(m_err));
  endtask

  task automatic step(input string tag, input bit e, input bit r, input bit l, input int v);
    en = e; restart = r; div_load = l; div_value = DW'(v);
    @(posedge clk);
    model_edge(e, r, l, v);
    #1;
    compare_model(tag);
  endtask

  initial begin
    int tick_edges[$];
    bit en_seq[14];

    vecs[0]  = '{1,0,0,0, 0,0,0,5,0};
    vecs[1]  = '{1,0,0,0, 0,0,0,5,0};
    vecs[2]  = '{1,0,0,0, 0,0,0,5,0};
    vecs[3]  = '{1,0,0,0, 0,0,0,5,0};
    vecs[4]  = '{1,0,0,0, 1,1,1,5,0};
    vecs[5]  = '{1,0,0,0, 0,1,1,5,0};
    vecs[6]  = '{1,0,1,3, 0,1,1,3,0};
    vecs[7]  = '{1,0,0,0, 0,1,1,3,0};
    vecs[8]  = '{1,0,0,0, 0,1,1,3,0};
    vecs[9]  = '{1,0,0,0, 1,0,2,3,0};
    vecs[10] = '{1,0,1,0, 0,0,2,3,1};
    vecs[11] = '{1,0,0,0, 0,0,2,3,0};
    vecs[12] = '{1,0,0,0, 1,1,3,3,0};
    vecs[13] = '{0,0,0,0, 0,1,3,3,0};
    vecs[14] = '{0,0,0,0, 0,1,3,3,0};
    vecs[15] = '{1,0,0,0, 0,1,3,3,0};
    vecs[16] = '{1,0,0,0, 0,1,3,3,0};
    vecs[17] = '{1,0,0,0, 1,0,4,3,0};
    vecs[18] = '{1,1,0,0, 0,0,0,3,0};

    rst_n = 1'b0; en = 0; restart = 0; div_load = 0; div_value = '0;
    model_reset();
    #12;
    compare_model("reset");
    rst_n = 1'b1;

    // Directed vector table starting from the reset state.
    for (int i = 0; i < 19; i++) begin
      step($sformatf("vec%0d", i), vecs[i].en, vecs[i].rs, vecs[i].ld, int'(vecs[i].val));
      chk($sformatf("tbl%0d.tick", i),       32'(tick),       32'(vecs[i].e_tick));
      chk($sformatf("tbl%0d.clk_div", i),    32'(clk_div),    32'(vecs[i].e_cd));
      chk($sformatf("tbl%0d.tick_count", i), 32'(tick_count), 32'(vecs[i].e_tc));
      chk($sformatf("tbl%0d.div_active", i), 32'(div_active), 32'(vecs[i].e_da));
      chk($sformatf("tbl%0d.div_err", i),    32'(div_err),    32'(vecs[i].e_err));
    end

    // Load landing on a terminal edge suppresses the tick.
    step("pre_ld0", 1, 0, 0, 0);
    step("pre_ld1", 1, 0, 0, 0);
    step("ld_term", 1, 0, 1, 4);
    chk("ld_term_no_tick", 32'(tick), 32'd0);
    chk("ld_term_div", 32'(div_active), 32'd4);

    // en gap of 4 cycles with DIV 5 stretches tick spacing to 9.
    step("gap_ld", 1, 1, 1, 5);
    en_seq = '{1,1,1,1,1, 1,1,0,0,0,0,1,1,1};
    for (int i = 0; i < 14; i++) begin
      step($sformatf("gap%0d", i), en_seq[i], 0, 0, 0);
      if (tick) tick_edges.push_back(i);
    end
    chk("gap_tick_num", 32'(tick_edges.size()), 32'd2);
    if (tick_edges.size() == 2) chk("gap_spacing", 32'(tick_edges[1] - tick_edges[0]), 32'd9);

    // DIV 1: tick constant, clk_div toggles every edge, tick_count wraps 15->0->1.
    step("div1_ld", 1, 1, 1, 1);
    for (int i = 1; i <= 17; i++) begin
      step($sformatf("div1_%0d", i), 1, 0, 0, 0);
      chk($sformatf("div1_tick%0d", i), 32'(tick), 32'd1);
      chk($sformatf("div1_cd%0d", i), 32'(clk_div), 32'(i % 2));
      chk($sformatf("div1_tc%0d", i), 32'(tick_count), 32'(i % 16));
    end
    step("rs_term", 1, 1, 0, 0);
    chk("rs_term_tick", 32'(tick), 32'd0);
    chk("rs_term_tc", 32'(tick_count), 32'd0);
    chk("rs_term_cd", 32'(clk_div), 32'd0);

    // Asynchronous reset between edges.
    step("ar0", 1, 0, 0, 0);
    step("ar1", 1, 0, 0, 0);
    rst_n = 1'b0;
    #2;
    model_reset();
    compare_model("async_rst");
    #2;
    rst_n = 1'b1;

    // Randomized stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      step("rand",
           $urandom_range(0, 9) < 8,
           $urandom_range(0, 49) == 0,
           $urandom_range(0, 19) == 0,
           int'($urandom_range(0, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
